// File: rtl/alu_seq_if.sv
// Operation/result bundle between the control unit and alu_seq.
// The master drives the request; the slave returns the registered result and flags.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] y;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;
  logic             flag_n;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b,
    input  y, flag_z, flag_c, flag_v, flag_n, busy, done
  );

  modport slave (
    input  start, op, a, b,
    output y, flag_z, flag_c, flag_v, flag_n, busy, done
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with start/done handshake and Z/C/V/N flags.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier (op 12).
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic      clk,
  input logic      reset,
  alu_seq_if.slave bus
);
  localparam int               MSB     = WIDTH - 1;
  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [3:0]       OP_MUL  = 4'd12;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             c;
    logic             v;
  } alu_res_t;

  function automatic alu_res_t alu_eval(
    input logic [3:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             c_in
  );
    alu_res_t       r;
    logic [WIDTH:0] sum;
    r.y = ZERO;
    r.c = 1'b0;
    r.v = 1'b0;
    sum = {(WIDTH+1){1'b0}};
    case (op)
      4'd0: r.y = a;
      4'd1: r.y = ~a;
      4'd2: begin
        sum = {1'b0, a} + {1'b0, b};
        r.y = sum[WIDTH-1:0];
        r.c = sum[WIDTH];
        r.v = (a[MSB] == b[MSB]) && (r.y[MSB] != a[MSB]);
      end
      4'd3: begin
        r.y = a - b;
        r.c = (a < b);
        r.v = (a[MSB] != b[MSB]) && (r.y[MSB] != a[MSB]);
      end
      4'd4: r.y = a & b;
      4'd5: r.y = a | b;
      4'd6: begin
        r.y = ZERO - a;
        r.c = (a != ZERO);
        r.v = (a == MIN_NEG);
      end
      4'd7: begin
        r.y = ZERO - b;
        r.c = (b != ZERO);
        r.v = (b == MIN_NEG);
      end
      4'd8: r.y = a ^ b;
      4'd9: begin
        r.y = {a[MSB-1:0], 1'b0};
        r.c = a[MSB];
        r.v = a[MSB] ^ a[MSB-1];
      end
      4'd10: begin
        r.y = {1'b0, a[MSB:1]};
        r.c = a[0];
      end
      4'd11: begin
        // ADC chains on the carry left by the previous operation
        sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
        r.y = sum[WIDTH-1:0];
        r.c = sum[WIDTH];
        r.v = (a[MSB] == b[MSB]) && (r.y[MSB] != a[MSB]);
      end
      default: r.y = ZERO;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] y_q, y_d;
  logic             z_q, z_d;
  logic             c_q, c_d;
  logic             v_q, v_d;
  logic             n_q, n_d;
  logic             done_q, done_d;
  alu_res_t         res_s;
  logic             single_s;

  assign res_s = alu_eval(bus.op, bus.a, bus.b, c_q);

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] acc_sum_s;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mul_fin_s;

  assign single_s  = (state_q == S_IDLE) && bus.start && (bus.op != OP_MUL);
  assign mul_fin_s = (state_q == S_MUL) && (cnt_q == CNT_LAST);
  assign acc_sum_s = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});

  // Multiplier sequencing: one partial product per cycle
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && (bus.op == OP_MUL)) begin
          state_d  = S_MUL;
          busy_d   = 1'b1;
          mcand_d  = {{WIDTH{1'b0}}, bus.a};
          mplier_d = bus.b;
          acc_d    = {(2*WIDTH){1'b0}};
          cnt_d    = {CNT_W{1'b0}};
        end else begin
          busy_d = 1'b0;
        end
      end
      S_MUL: begin
        acc_d    = acc_sum_s;
        mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Multiplier state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      mcand_q  <= {(2*WIDTH){1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.busy = busy_q;
`else
  assign single_s = bus.start;
  assign bus.busy = 1'b0;
`endif

  // Result and flag update; values hold between operations
  always_comb begin
    y_d    = y_q;
    z_d    = z_q;
    c_d    = c_q;
    v_d    = v_q;
    n_d    = n_q;
    done_d = 1'b0;
    if (single_s) begin
      y_d    = res_s.y;
      c_d    = res_s.c;
      v_d    = res_s.v;
      z_d    = (res_s.y == ZERO);
      n_d    = res_s.y[MSB];
      done_d = 1'b1;
    end
`ifdef ALU_SEQ_MUL_EN
    else if (mul_fin_s) begin
      // final partial product folded in on the same edge that retires the op
      y_d    = acc_sum_s[WIDTH-1:0];
      c_d    = (acc_sum_s[2*WIDTH-1:WIDTH] != ZERO);
      v_d    = 1'b0;
      z_d    = (acc_sum_s[WIDTH-1:0] == ZERO);
      n_d    = acc_sum_s[MSB];
      done_d = 1'b1;
    end
`endif
    else begin
      done_d = 1'b0;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      y_q    <= ZERO;
      z_q    <= 1'b0;
      c_q    <= 1'b0;
      v_q    <= 1'b0;
      n_q    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      y_q    <= y_d;
      z_q    <= z_d;
      c_q    <= c_d;
      v_q    <= v_d;
      n_q    <= n_d;
      done_q <= done_d;
    end
  end

  assign bus.y      = y_q;
  assign bus.flag_z = z_q;
  assign bus.flag_c = c_q;
  assign bus.flag_v = v_q;
  assign bus.flag_n = n_q;
  assign bus.done   = done_q;
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the CPU's 8-bit combinational ALU.
- Adds a start/done handshake, registered result and flags (Z, C, V, N), and carry-chained and shift operations.
- Adds an optional iterative shift-add multiplier that takes WIDTH cycles.
- Sits between the register file and the write-back mux. The control unit holds the pipeline off while busy=1.

Parameters:
- WIDTH, 8, data width in bits (>=4).
- CNT_W, $clog2(WIDTH)+1, width of the multiply iteration counter (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request an operation; sampled only in IDLE
- op  input  4  operation code, captured with start
- a  input  WIDTH  operand A, captured with start
- b  input  WIDTH  operand B, captured with start
- y  output  WIDTH  registered result
- flag_z  output  1  y == 0
- flag_c  output  1  carry/borrow/shift-out
- flag_v  output  1  signed overflow
- flag_n  output  1  y[WIDTH-1]
- busy  output  1  multi-cycle operation in progress
- done  output  1  one-cycle pulse: y and flags were updated this cycle

Behaviour:
- Reset:
  - y=0, all flags=0, busy=0, done=0, state=IDLE, multiplier registers cleared.
  - reset wins over start in the same cycle.
  - reset mid-multiply aborts the operation with no done pulse.
- op, a and b are captured at the edge where start=1 in IDLE. Later input changes have no effect.
- start while busy=1 is ignored: no queueing, no error.
- Opcodes (unsigned arithmetic mod 2^WIDTH; flag rules in brackets):
  - 0 y=a [C=0, V=0]
  - 1 y=~a [C=0, V=0]
  - 2 y=a+b [C=carry-out; V=signed overflow]
  - 3 y=a-b [C=borrow (a<b unsigned); V=signed overflow]
  - 4 y=a&b; 5 y=a|b; 6 y=-a; 7 y=-b
    - ops 4, 5: C=0, V=0
    - ops 6, 7: C=operand!=0; V=operand==100..0
  - 8 y=a^b [C=0, V=0]
  - 9 y=a<<1 [C=a[MSB], V=a[MSB]^a[MSB-1]]
  - 10 y=a>>1 logical [C=a[0], V=0]
  - 11 y=a+b+flag_c (ADC, uses the registered C from the previous op) [C, V as op 2]
  - 12 MUL, see below
  - 13–15 reserved: y=0, Z=1, C=0, V=0, N=0, 1-cycle latency
- For every op: Z and N are recomputed from the new y.
- Single-cycle ops: state stays IDLE. y, flags and done=1 appear in the cycle after the start edge (latency 1). done is high for exactly 1 cycle.
- MUL FSM: IDLE -> MUL on start with op=12.
  - MUL state:
    - busy=1.
    - Each cycle adds the multiplicand to a 2*WIDTH accumulator if the current multiplier bit is set, then shifts the multiplicand and multiplier.
    - cnt counts 0..WIDTH-1.
  - On the cycle after cnt=WIDTH-1: go to IDLE, busy=0, done=1.
    - y = product[WIDTH-1:0].
    - C = (product[2W-1:W] != 0).
    - V=0; Z and N from y.
  - Total latency: WIDTH+1 cycles from the start edge to done. busy is high for WIDTH cycles.
- y and flags hold their values between operations. done and busy are never both 1.

Optional Feature:
- Macro ALU_SEQ_MUL_EN.
- Defined: MUL datapath, counter and MUL state are compiled in as described above.
- Undefined: no MUL state or multiplier registers exist. op 12 behaves exactly as reserved (y=0, Z=1, latency 1), and busy is tied to 0.

Test Plan:
- WIDTH=8; reset for 2 cycles; then start, op=2, a=0xFF, b=0x01 -> one cycle later y=0x00, Z=1, C=1, V=0, N=0, done=1 for 1 cycle.
- op=3, a=0x80, b=0x01 -> y=0x7F, C=0, V=1, N=0. Then op=11, a=0x01, b=0x01 with C=0 -> y=0x02.
  - Also op=2, a=0xF0, b=0x20 (sets C=1), then op=11, a=0x00, b=0x00 -> y=0x01.
- MUL enabled: op=12, a=0x10, b=0x11 -> busy=1 for 8 cycles, done at cycle 9, y=0x10, C=1.
  - Also a=0x0F, b=0x03 -> y=0x2D, C=0.
- During a MUL, pulse start with op=0, a=0x55 -> ignored. The MUL result is unaffected and exactly one done pulse occurs.
- Assert reset at cycle 4 of a MUL -> next cycle y=0, flags=0, busy=0, and no done pulse afterwards.
- MUL disabled: op=12, a=0x10, b=0x11 -> 1 cycle later y=0, Z=1, busy never asserted. op=9, a=0xC1 -> y=0x82, C=1, V=0.
